sha256_compress: RTL and testbench



---
 rtl/sha_const.sv | 103 ++++++++++
 rtl/sha256_round.sv | 21 ++
 rtl/sha256_compress.sv | 112 +++++++++++
 tb/tb_sha256_compress.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_const.sv
// Shared SHA-256 constants, register types and round helper functions.
// Build option SHA224_EN selects the SHA-224 initial value.
package sha_const;

   localparam int unsigned Nw     = 32;
   localparam int unsigned Nb     = 512;
   localparam int unsigned Nm     = 64;
   localparam int unsigned NROUND = 64;

   typedef logic [Nw-1:0] word_t;

   typedef struct packed {
      word_t a;
      word_t b;
      word_t c;
      word_t d;
      word_t e;
      word_t f;
      word_t g;
      word_t h;
   } work_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROUND  = 2'd1,
      UPDATE = 2'd2
   } state_e;

   localparam word_t K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam word_t IV256 [0:7] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam word_t IV224 [0:7] = '{
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
   };

`ifdef SHA224_EN
   localparam work_t IV_WORK = '{IV224[0], IV224[1], IV224[2], IV224[3],
                                 IV224[4], IV224[5], IV224[6], IV224[7]};
`else
   localparam work_t IV_WORK = '{IV256[0], IV256[1], IV256[2], IV256[3],
                                 IV256[4], IV256[5], IV256[6], IV256[7]};
`endif

   function automatic word_t ror(input word_t x, input int unsigned n);
      return (x >> n) | (x << (Nw - n));
   endfunction

   function automatic word_t ch(input word_t x, input word_t y, input word_t z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic word_t maj(input word_t x, input word_t y, input word_t z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   function automatic word_t S0(input word_t x);
      return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
   endfunction

   function automatic word_t S1(input word_t x);
      return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
   endfunction

   function automatic word_t s0(input word_t x);
      return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
   endfunction

   function automatic word_t s1(input word_t x);
      return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
   endfunction

   function automatic word_t bswap32(input word_t x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   function automatic work_t add_work(input work_t x, input work_t y);
      return '{x.a + y.a, x.b + y.b, x.c + y.c, x.d + y.d,
               x.e + y.e, x.f + y.f, x.g + y.g, x.h + y.h};
   endfunction

endpackage

// File: rtl/sha256_round.sv
// Combinational single SHA-256 compression round.
module sha256_round
   import sha_const::*;
(
   input  work_t st_i,
   input  word_t k_i,
   input  word_t w_i,
   output work_t st_o
);

   word_t t1;
   word_t t2;

   always_comb begin
      t1   = st_i.h + S1(st_i.e) + ch(st_i.e, st_i.f, st_i.g) + k_i + w_i;
      t2   = S0(st_i.a) + maj(st_i.a, st_i.b, st_i.c);
      st_o = '{t1 + t2, st_i.a, st_i.b, st_i.c,
               st_i.d + t1, st_i.e, st_i.f, st_i.g};
   end

endmodule

// File: rtl/sha256_compress.sv
// SHA-256 block compression core: one round per clock, chaining value kept across blocks.
// Define SHA224_EN for the SHA-224 initial value and a 224-bit digest on Hash[255:32].
module sha256_compress
   import sha_const::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic [Nb-1:0] Data,
   input  logic [Nm-1:0] Index,
   input  logic          Ready,
   input  logic          Last,
   output logic          Busy,
   output logic [255:0]  Hash,
   output logic          Hash_Valid
);

   typedef struct packed {
      state_e       state;
      logic [5:0]   t;
      logic         last;
      work_t        work;
      work_t        h;
      word_t [15:0] w;
      logic [255:0] hash;
      logic         hash_valid;
   } reg_t;

   localparam reg_t RESET_REG = '{
      state:      IDLE,
      t:          '0,
      last:       1'b0,
      work:       '0,
      h:          IV_WORK,
      w:          '0,
      hash:       '0,
      hash_valid: 1'b0
   };

   reg_t  r_q;
   reg_t  r_d;
   work_t round_out;
   work_t h_sum;
   work_t h_sel;

   sha256_round u_round (
      .st_i (r_q.work),
      .k_i  (K[r_q.t]),
      .w_i  (r_q.w[0]),
      .st_o (round_out)
   );

   always_comb begin
      r_d            = r_q;
      r_d.hash_valid = 1'b0;
      h_sum          = add_work(r_q.h, r_q.work);
      h_sel          = (Index == '0) ? IV_WORK : r_q.h;

      unique case (r_q.state)
         IDLE: begin
            if (Ready) begin
               for (int unsigned i = 0; i < 16; i++) begin
                  r_d.w[i] = bswap32(Data[i*Nw +: Nw]);
               end
               r_d.h     = h_sel;
               r_d.work  = h_sel;
               r_d.last  = Last;
               r_d.t     = '0;
               r_d.state = ROUND;
            end
         end
         ROUND: begin
            r_d.work = round_out;
            // w[0] is consumed this round; the expanded word enters at the top
            for (int unsigned i = 0; i < 15; i++) begin
               r_d.w[i] = r_q.w[i+1];
            end
            r_d.w[15] = s1(r_q.w[14]) + r_q.w[9] + s0(r_q.w[1]) + r_q.w[0];
            r_d.t     = r_q.t + 6'd1;
            if (r_q.t == 6'(NROUND - 1)) begin
               r_d.state = UPDATE;
            end
         end
         UPDATE: begin
            r_d.h = h_sum;
            if (r_q.last) begin
`ifdef SHA224_EN
               r_d.hash = {h_sum.a, h_sum.b, h_sum.c, h_sum.d,
                           h_sum.e, h_sum.f, h_sum.g, 32'h0};
`else
               r_d.hash = h_sum;
`endif
               r_d.hash_valid = 1'b1;
            end
            r_d.state = IDLE;
         end
         default: r_d.state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_q <= RESET_REG;
      end else begin
         r_q <= r_d;
      end
   end

   assign Busy       = (r_q.state != IDLE);
   assign Hash       = r_q.hash;
   assign Hash_Valid = r_q.hash_valid;

endmodule

// File: tb/tb_sha256_compress.sv
// Self-checking bench for sha256_compress using known SHA-256/SHA-224 digests.
module tb_sha256_compress;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [511:0] Data = '0;
   logic [63:0]  Index = '0;
   logic         Ready = 1'b0;
   logic         Last = 1'b0;
   logic         Busy;
   logic [255:0] Hash;
   logic         Hash_Valid;

   always #5 clk = ~clk;

   sha256_compress dut (
      .clk        (clk),
      .rst        (rst),
      .Data       (Data),
      .Index      (Index),
      .Ready      (Ready),
      .Last       (Last),
      .Busy       (Busy),
      .Hash       (Hash),
      .Hash_Valid (Hash_Valid)
   );

   typedef struct {
      logic [255:0] hash;
      int unsigned  edge_no;
   } exp_t;

   exp_t        sb[$];
   int unsigned tests = 0;
   int unsigned fails = 0;
   int unsigned cyc   = 0;
   int unsigned viol  = 0;

   localparam string MSG_ABC = "abc";
   localparam string MSG_EMP = "";
   localparam string MSG_2B  = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";

`ifdef SHA224_EN
   localparam logic [255:0] D_ABC = {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};
   localparam logic [255:0] D_EMP = {224'hd14a028c2a3a2bc9476102bb288234c415a2b01f828ea62ac5b3e42f, 32'h0};
   localparam logic [255:0] D_2B  = {224'h75388b16512776cc5dba5da1fd890150b0c6455cb4f58b1952522525, 32'h0};
`else
   localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] D_EMP = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] D_2B  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
`endif

   always @(posedge clk) cyc <= cyc + 1;

   // Upstream must not raise Ready while the core is busy; count each offending edge.
   always @(posedge clk) begin
      if (rst && Ready && Busy) begin
         viol = viol + 1;
         $display("[TB] protocol: Ready asserted while Busy at cycle %0d", cyc);
      end
   end

   always @(negedge clk) begin
      if (Hash_Valid) begin
         exp_t e;
         tests = tests + 1;
         if (sb.size() == 0) begin
            fails = fails + 1;
            $display("FAIL unexpected_hash_valid: Hash=%h at cycle %0d, required no pulse", Hash, cyc);
         end else begin
            e = sb.pop_front();
            if (Hash !== e.hash) begin
               fails = fails + 1;
               $display("FAIL digest: got %h, required %h", Hash, e.hash);
            end
            tests = tests + 1;
            if (cyc != e.edge_no + 65) begin
               fails = fails + 1;
               $display("FAIL latency: pulse at cycle %0d, required %0d", cyc, e.edge_no + 65);
            end
         end
      end
   end

   function automatic logic [511:0] pad_block(input string m, input int blk);
      int           len;
      int           plen;
      logic [63:0]  bits;
      logic [511:0] d;
      len  = m.len();
      plen = ((len + 9 + 63) / 64) * 64;
      bits = 64'(len) * 64'd8;
      d    = '0;
      for (int k = 0; k < 64; k++) begin
         int        p;
         logic [7:0] b;
         p = blk * 64 + k;
         if (p < len)            b = m[p];
         else if (p == len)      b = 8'h80;
         else if (p >= plen - 8) b = bits[(plen - 1 - p) * 8 +: 8];
         else                    b = 8'h00;
         d[k*8 +: 8] = b;
      end
      return d;
   endfunction

   task automatic send(input string m, input int blk, input logic [63:0] idx,
                       input logic lst, input logic [255:0] exp_hash,
                       output int unsigned acc_edge);
      int unsigned n = 0;
      exp_t e;
      while (Busy !== 1'b0 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 500) begin
         tests = tests + 1;
         fails = fails + 1;
         $display("FAIL send_wait: Busy=%b after %0d cycles, required 0", Busy, n);
      end
      Data  = pad_block(m, blk);
      Index = idx;
      Last  = lst;
      Ready = 1'b1;
      @(posedge clk); #1;
      acc_edge = cyc;
      Ready = 1'b0;
      if (lst) begin
         e.hash    = exp_hash;
         e.edge_no = acc_edge;
         sb.push_back(e);
      end
   endtask

   task automatic drain(input string name);
      int unsigned n = 0;
      while ((sb.size() != 0 || Busy !== 1'b0) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      tests = tests + 1;
      if (sb.size() != 0 || Busy !== 1'b0) begin
         fails = fails + 1;
         $display("FAIL %s_timeout: pending=%0d Busy=%b, required 0 and 0", name, sb.size(), Busy);
         sb.delete();
      end
   endtask

   task automatic test_reset();
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests = tests + 3;
      if (Busy !== 1'b0) begin
         fails = fails + 1;
         $display("FAIL reset_busy: got %b, required 0", Busy);
      end
      if (Hash_Valid !== 1'b0) begin
         fails = fails + 1;
         $display("FAIL reset_valid: got %b, required 0", Hash_Valid);
      end
      if (Hash !== 256'h0) begin
         fails = fails + 1;
         $display("FAIL reset_hash: got %h, required 0", Hash);
      end
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_abc();
      int unsigned e0;
      send(MSG_ABC, 0, 64'd0, 1'b1, D_ABC, e0);
      drain("abc");
      tests = tests + 1;
      if (Hash !== D_ABC) begin
         fails = fails + 1;
         $display("FAIL abc_hold: got %h, required %h", Hash, D_ABC);
      end
   endtask

   task automatic test_empty();
      int unsigned e0;
      send(MSG_EMP, 0, 64'd0, 1'b1, D_EMP, e0);
      drain("empty");
   endtask

   task automatic test_back_to_back();
      int unsigned e0;
      int unsigned e1;
      send(MSG_2B, 0, 64'd0, 1'b0, '0, e0);
      send(MSG_2B, 1, 64'd1, 1'b1, D_2B, e1);
      tests = tests + 1;
      if (e1 - e0 != 66) begin
         fails = fails + 1;
         $display("FAIL b2b_spacing: accepted %0d cycles apart, required 66", e1 - e0);
      end
      drain("b2b");
   endtask

   task automatic test_busy_ignore();
      int unsigned e0;
      int unsigned v0;
      v0 = viol;
      send(MSG_ABC, 0, 64'd0, 1'b1, D_ABC, e0);
      repeat (10) @(posedge clk);
      #1;
      tests = tests + 1;
      if (Busy !== 1'b1) begin
         fails = fails + 1;
         $display("FAIL busy_round10: got %b, required 1", Busy);
      end
      Data  = pad_block(MSG_EMP, 0);
      Index = 64'd0;
      Last  = 1'b1;
      Ready = 1'b1;
      @(posedge clk); #1;
      Ready = 1'b0;
      drain("ignore");
      tests = tests + 2;
      if (Hash !== D_ABC) begin
         fails = fails + 1;
         $display("FAIL ignore_hash: got %h, required %h", Hash, D_ABC);
      end
      if (viol - v0 != 1) begin
         fails = fails + 1;
         $display("FAIL protocol_flag: got %0d violations, required 1", viol - v0);
      end
   endtask

   task automatic test_reset_abort();
      int unsigned e0;
      send(MSG_ABC, 0, 64'd0, 1'b1, D_ABC, e0);
      repeat (30) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      sb.delete();
      tests = tests + 3;
      if (Busy !== 1'b0) begin
         fails = fails + 1;
         $display("FAIL abort_busy: got %b, required 0", Busy);
      end
      if (Hash !== 256'h0) begin
         fails = fails + 1;
         $display("FAIL abort_hash: got %h, required 0", Hash);
      end
      if (Hash_Valid !== 1'b0) begin
         fails = fails + 1;
         $display("FAIL abort_valid: got %b, required 0", Hash_Valid);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      // Nonzero Index on the first block after reset must still start from the IV.
      send(MSG_ABC, 0, 64'd1, 1'b1, D_ABC, e0);
      drain("fresh");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_abc();
      test_empty();
      test_back_to_back();
      test_busy_ignore();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
